prog_loader: RTL and testbench

//  Owns the 16x8 program memory of the 4-bit CPU and sequences the CPU around it.
//  A host streams 16 instruction bytes over a valid/ready handshake while the CPU is held in reset.
//  The block then releases CPU reset, serves instruction fetches and counts run cycles until halted or reloaded.

---
 rtl/prog_loader_pkg.sv | 19 +
 rtl/prog_loader_if.sv | 10 +
 rtl/prog_loader_ram.sv | 38 +++
 rtl/prog_loader.sv | 135 +++++++++++++
 tb/tb_prog_loader.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the TD4 program loader: address/data widths,
// the NOP fill value and the loader FSM state encoding.
package td4_pkg;
  localparam int TD4_ADDR_W = 4;
  localparam int TD4_DATA_W = 8;
  localparam logic [TD4_DATA_W-1:0] TD4_NOP = 8'h00;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] RUN  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_LOAD = LOAD,
    ST_HOLD = HOLD,
    ST_RUN  = RUN
  } state_e;
endpackage

// File: rtl/prog_loader_if.sv
// Host byte-stream write bus into the program loader (valid/ready).
interface prog_loader_if;
  import td4_pkg::*;
  logic                  wr_valid;
  logic [TD4_DATA_W-1:0] wr_data;
  logic                  wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/prog_loader_ram.sv
// prog_ram: DEPTH x DATA_W program store. Synchronous write, asynchronous
// read, whole array cleared to NOP by the asynchronous reset (so it is built
// from flops, one register per word).
module prog_ram
  import td4_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = TD4_DATA_W,
  parameter int ADDR_W = TD4_ADDR_W
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] rd_words [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [DATA_W-1:0] word_q;
      // One word register: cleared on reset, loaded when addressed by a write.
      always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
          word_q <= TD4_NOP;
        end else if (we && (waddr == ADDR_W'(gi))) begin
          word_q <= wdata;
        end
      end
      assign rd_words[gi] = word_q;
    end
  endgenerate

  assign rdata = rd_words[raddr];
endmodule

// File: rtl/prog_loader.sv
// prog_loader: owns the TD4 program memory, streams a program in from the
// host while the CPU is held in reset, then releases the CPU and counts run
// cycles. Optional feature macro: PROG_LOADER_CHECKSUM_EN adds a checksum
// output (mod-256 sum of bytes accepted in the current load).
module prog_loader
  import td4_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int DATA_W      = TD4_DATA_W,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  load_start,
  input  logic                  run_start,
  input  logic                  halt,
  prog_loader_if.slave          wr_bus,
  output logic                  cpu_n_reset,
  input  logic [TD4_ADDR_W-1:0] cpu_address,
  output logic [DATA_W-1:0]     cpu_instr,
`ifdef PROG_LOADER_CHECKSUM_EN
  output logic [7:0]            checksum,
`endif
  output logic                  busy,
  output logic [7:0]            run_cycles
);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e                  state_q, state_d;
  logic [TD4_ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [HW-1:0]           hold_cnt_q, hold_cnt_d;
  logic [7:0]              run_cycles_q, run_cycles_d;
  logic                    cpu_n_reset_q, cpu_n_reset_d;
  logic                    beat;

  assign wr_bus.wr_ready = (state_q == ST_LOAD);
  assign beat            = wr_bus.wr_valid && (state_q == ST_LOAD);
  assign busy            = (state_q == ST_LOAD) || (state_q == ST_HOLD);
  assign run_cycles      = run_cycles_q;
  assign cpu_n_reset     = cpu_n_reset_q;

  prog_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(TD4_ADDR_W)) u_ram (
    .clk     (clk),
    .n_reset (n_reset),
    .we      (beat),
    .waddr   (wr_ptr_q),
    .wdata   (wr_bus.wr_data),
    .raddr   (cpu_address),
    .rdata   (cpu_instr)
  );

  // Next-state logic: sequencing, write pointer, hold and run counters.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    hold_cnt_d   = hold_cnt_q;
    run_cycles_d = run_cycles_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
        end else if (run_start) begin
          state_d      = ST_HOLD;
          hold_cnt_d   = '0;
          run_cycles_d = '0;
        end
      end
      ST_LOAD: begin
        if (beat) wr_ptr_d = wr_ptr_q + 1'b1;
        if (halt) begin
          // Abandon the load; whatever was written stays in memory.
          state_d  = ST_IDLE;
          wr_ptr_d = '0;
        end else if (beat && (wr_ptr_q == TD4_ADDR_W'(DEPTH - 1))) begin
          state_d      = ST_HOLD;
          hold_cnt_d   = '0;
          run_cycles_d = '0;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) state_d = ST_RUN;
        else                                   hold_cnt_d = hold_cnt_q + 1'b1;
      end
      ST_RUN: begin
        if (run_cycles_q != 8'hFF) run_cycles_d = run_cycles_q + 8'd1;
        if (halt) begin
          state_d = ST_IDLE;
        end else if (load_start) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered CPU reset release: high exactly while the FSM sits in RUN.
    cpu_n_reset_d = (state_d == ST_RUN);
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      hold_cnt_q    <= '0;
      run_cycles_q  <= '0;
      cpu_n_reset_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      run_cycles_q  <= run_cycles_d;
      cpu_n_reset_q <= cpu_n_reset_d;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;

  // Checksum restarts on every entry into LOAD and accumulates accepted bytes.
  always_comb begin
    checksum_d = checksum_q;
    if ((state_q != ST_LOAD) && (state_d == ST_LOAD)) checksum_d = 8'h00;
    else if (beat)                                    checksum_d = checksum_q + 8'(wr_bus.wr_data);
  end

  // Checksum register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) checksum_q <= 8'h00;
    else          checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a byte scoreboard for the memory image.
module tb_prog_loader;
  import td4_pkg::*;

  logic       clk        = 1'b0;
  logic       n_reset    = 1'b1;
  logic       load_start = 1'b0;
  logic       run_start  = 1'b0;
  logic       halt       = 1'b0;
  logic [3:0] cpu_address = 4'h0;
  logic       cpu_n_reset;
  logic [7:0] cpu_instr;
  logic       busy;
  logic [7:0] run_cycles;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  prog_loader_if bus ();

  prog_loader #(.DEPTH(16), .DATA_W(8), .HOLD_CYCLES(2)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .load_start  (load_start),
    .run_start   (run_start),
    .halt        (halt),
    .wr_bus      (bus.slave),
    .cpu_n_reset (cpu_n_reset),
    .cpu_address (cpu_address),
    .cpu_instr   (cpu_instr),
`ifdef PROG_LOADER_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .busy        (busy),
    .run_cycles  (run_cycles)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q [$];
  logic [7:0] model_mem [16];
  logic [7:0] model_sum = 8'h00;
  logic [7:0] prog_a [16] = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
                              8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};
  logic [7:0] prog_b [16];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sum(input string tag);
`ifdef PROG_LOADER_CHECKSUM_EN
    check(tag, 16'(checksum), 16'(model_sum));
`endif
  endtask

  // Drain the scoreboard against the memory image seen on cpu_instr.
  task automatic check_image(input string tag);
    if (exp_q.size() == 0)
      for (int a = 0; a < 16; a++) exp_q.push_back(model_mem[a]);
    check({tag, "_qsize"}, 16'(exp_q.size()), 16'd16);
    for (int a = 0; a < 16; a++) begin
      cpu_address = 4'(a);
      #1;
      if (exp_q.size() > 0) check(tag, 16'(cpu_instr), 16'(exp_q.pop_front()));
    end
    exp_q.delete();
  endtask

  task automatic load_prog(input logic [7:0] img [16], input bit rnd);
    int  i;
    int  guard;
    bit  v;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("load_busy", 16'(busy), 16'd1);
    check("load_ready", 16'(bus.wr_ready), 16'd1);
    model_sum = 8'h00;
    exp_q.delete();
    i = 0;
    guard = 0;
    while (i < 16 && guard < 400) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.wr_valid = v;
      bus.wr_data  = v ? img[i] : 8'($urandom);
      if (v && bus.wr_ready) begin
        exp_q.push_back(img[i]);
        model_mem[i] = img[i];
        model_sum    = model_sum + img[i];
        i++;
      end
      tick();
      guard++;
    end
    bus.wr_valid = 1'b0;
    check("load_beats", 16'(i), 16'd16);
    check("hold_nrst0", 16'(cpu_n_reset), 16'd0);
    check("hold_busy", 16'(busy), 16'd1);
    tick();
    check("hold_nrst1", 16'(cpu_n_reset), 16'd0);
    tick();
    check("run_nrst", 16'(cpu_n_reset), 16'd1);
    check("run_busy", 16'(busy), 16'd0);
    check("run_cyc0", 16'(run_cycles), 16'd0);
    check_sum("load_csum");
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    for (int a = 0; a < 16; a++) model_mem[a] = 8'h00;
    for (int a = 0; a < 16; a++) prog_b[a] = 8'($urandom);

    // Asynchronous reset state.
    #2 n_reset = 1'b0;
    #1;
    check("rst_nrst", 16'(cpu_n_reset), 16'd0);
    check("rst_ready", 16'(bus.wr_ready), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_cycles", 16'(run_cycles), 16'd0);
    check_sum("rst_csum");
    #3 n_reset = 1'b1;
    repeat (5) tick();
    check("idle_nrst", 16'(cpu_n_reset), 16'd0);
    check("idle_ready", 16'(bus.wr_ready), 16'd0);
    check_image("rst_img");

    // wr_valid while idle must not write.
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hAA;
    tick();
    tick();
    bus.wr_valid = 1'b0;
    check("idle_wr_busy", 16'(busy), 16'd0);
    check_image("idle_wr_img");

    // Ramen-timer program, one byte per cycle.
    load_prog(prog_a, 1'b0);
    repeat (10) tick();
    check("run_cyc10", 16'(run_cycles), 16'd10);
    check_image("load_a_img");
`ifdef PROG_LOADER_CHECKSUM_EN
    check("csum_const", 16'(checksum), 16'h0009);
`endif

    // Same program with gappy wr_valid, started from RUN.
    load_prog(prog_a, 1'b1);
    check_image("load_rnd_img");

    // Saturating run counter, then halt.
    repeat (300) tick();
    check("run_sat", 16'(run_cycles), 16'd255);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt_nrst", 16'(cpu_n_reset), 16'd0);
    check("halt_busy", 16'(busy), 16'd0);
    tick();
    check("halt_cyc_hold", 16'(run_cycles), 16'd255);

    // run_start from IDLE: two hold cycles then RUN.
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    check("rs_busy", 16'(busy), 16'd1);
    check("rs_nrst0", 16'(cpu_n_reset), 16'd0);
    tick();
    check("rs_nrst1", 16'(cpu_n_reset), 16'd0);
    tick();
    check("rs_nrst2", 16'(cpu_n_reset), 16'd1);
    check("rs_cyc0", 16'(run_cycles), 16'd0);

    // halt and load_start together in RUN: halt wins.
    halt = 1'b1;
    load_start = 1'b1;
    tick();
    halt = 1'b0;
    load_start = 1'b0;
    check("hl_busy", 16'(busy), 16'd0);
    check("hl_ready", 16'(bus.wr_ready), 16'd0);
    check("hl_nrst", 16'(cpu_n_reset), 16'd0);
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    check("hl_rs_busy", 16'(busy), 16'd1);
    tick();
    tick();
    check("hl_rs_nrst", 16'(cpu_n_reset), 16'd1);
    check_image("rerun_img");

    // Reset in the middle of a load.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = prog_b[k];
      tick();
    end
    bus.wr_valid = 1'b0;
    n_reset = 1'b0;
    #1;
    for (int a = 0; a < 16; a++) model_mem[a] = 8'h00;
    model_sum = 8'h00;
    exp_q.delete();
    check("mid_ready", 16'(bus.wr_ready), 16'd0);
    check("mid_busy", 16'(busy), 16'd0);
    check("mid_nrst", 16'(cpu_n_reset), 16'd0);
    check_sum("mid_csum");
    check_image("mid_img");
    n_reset = 1'b1;

    // Full reload after the aborted one lands at address 0 onward.
    load_prog(prog_b, 1'b0);
    check_image("reload_img");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
